// File: rtl/lsu_axi_master.sv
// Load/store unit bus engine: runs one EXU memory request at a time as an AXI-lite master and
// returns lane-steered, extended load data or store completion with an error code.
module lsu_axi_master #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_func3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [1:0]        resp_err,
   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [XLEN-1:0]   m_araddr,
   output logic [2:0]        m_arsize,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [XLEN-1:0]   m_rdata,
   input  logic [1:0]        m_rresp,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [XLEN-1:0]   m_awaddr,
   output logic [2:0]        m_awsize,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [XLEN-1:0]   m_wdata,
   output logic [XLEN/8-1:0] m_wstrb,
   input  logic              m_bvalid,
   output logic              m_bready,
   input  logic [1:0]        m_bresp
);

   localparam int unsigned SW = XLEN / 8;
   localparam int unsigned OW = $clog2(SW);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StAr   = 3'd1;
   localparam logic [2:0] StR    = 3'd2;
   localparam logic [2:0] StAww  = 3'd3;
   localparam logic [2:0] StB    = 3'd4;
   localparam logic [2:0] StResp = 3'd5;

   localparam logic [1:0] ErrOk       = 2'd0;
   localparam logic [1:0] ErrMisalign = 2'd1;
   localparam logic [1:0] ErrBus      = 2'd2;
   localparam logic [1:0] ErrTimeout  = 2'd3;

   logic [2:0]      state_q, state_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [1:0]      err_q, err_d;

   // Request-side decode: alignment, store lane steering.
   logic [1:0]      req_size;
   logic [OW-1:0]   req_off;
   logic [XLEN-1:0] align_mask;
   logic            misaligned;
   logic [XLEN-1:0] wdata_shift;
   logic [15:0]     strb_base;
   logic [15:0]     strb_shift;

   always_comb begin
      req_size    = req_func3[1:0];
      req_off     = req_addr[OW-1:0];
      align_mask  = (XLEN'(1) << req_size) - XLEN'(1);
      misaligned  = (32'(req_size) > OW) || ((req_addr & align_mask) != '0);
      wdata_shift = req_wdata << {req_off, 3'b000};
      strb_base   = (16'd1 << (16'd1 << req_size)) - 16'd1;
      strb_shift  = strb_base << req_off;
   end

   // Load-side lane extraction and sign/zero extension.
   logic [XLEN-1:0] r_shift;
   logic [XLEN-1:0] keep;
   logic            sign_bit;
   logic [XLEN-1:0] r_ext;

   always_comb begin
      r_shift = m_rdata >> {addr_q[OW-1:0], 3'b000};
      case (size_q)
         2'd0: begin
            keep     = XLEN'(8'hFF);
            sign_bit = r_shift[7];
         end
         2'd1: begin
            keep     = XLEN'(16'hFFFF);
            sign_bit = r_shift[15];
         end
         2'd2: begin
            keep     = XLEN'(32'hFFFF_FFFF);
            sign_bit = r_shift[31];
         end
         default: begin
            keep     = '1;
            sign_bit = r_shift[XLEN-1];
         end
      endcase
      r_ext = (r_shift & keep) | (~keep & {XLEN{sign_bit & ~uns_q}});
   end

   logic timeout_hit;
   logic counting;
   logic aw_ok;
   logic w_ok;

   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      uns_d     = uns_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      aw_ok     = aw_done_q | m_awready;
      w_ok      = w_done_q | m_wready;
      timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
      counting    = (state_q == StAr) || (state_q == StR) || (state_q == StAww) ||
                    (state_q == StB);

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               size_d    = req_size;
               uns_d     = req_func3[2];
               addr_d    = req_addr;
               wdata_d   = wdata_shift;
               wstrb_d   = strb_shift[SW-1:0];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (misaligned) begin
                  state_d = StResp;
                  err_d   = ErrMisalign;
                  rdata_d = '0;
               end else if (req_we) begin
                  state_d = StAww;
               end else begin
                  state_d = StAr;
               end
            end
         end
         StAr: begin
            if (m_arready) begin
               state_d = StR;
            end else if (timeout_hit) begin
               state_d = StResp;
               err_d   = ErrTimeout;
               rdata_d = '0;
            end
         end
         StR: begin
            if (m_rvalid) begin
               state_d = StResp;
               err_d   = (m_rresp != 2'b00) ? ErrBus : ErrOk;
               rdata_d = (m_rresp != 2'b00) ? '0 : r_ext;
            end else if (timeout_hit) begin
               state_d = StResp;
               err_d   = ErrTimeout;
               rdata_d = '0;
            end
         end
         StAww: begin
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (aw_ok && w_ok) begin
               state_d = StB;
            end else if (timeout_hit) begin
               state_d = StResp;
               err_d   = ErrTimeout;
               rdata_d = '0;
            end
         end
         StB: begin
            if (m_bvalid) begin
               state_d = StResp;
               err_d   = (m_bresp != 2'b00) ? ErrBus : ErrOk;
               rdata_d = '0;
            end else if (timeout_hit) begin
               state_d = StResp;
               err_d   = ErrTimeout;
               rdata_d = '0;
            end
         end
         StResp: begin
            state_d = StIdle;
            rdata_d = '0;
            err_d   = ErrOk;
         end
         default: begin
            state_d = StIdle;
            rdata_d = '0;
            err_d   = ErrOk;
         end
      endcase

      // The timer restarts on every state change so each channel gets its own budget.
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (counting && (TIMEOUT != 0)) begin
         timer_d = timer_q + 1'b1;
      end else begin
         timer_d = timer_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         size_q    <= '0;
         uns_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         timer_q   <= '0;
         rdata_q   <= '0;
         err_q     <= ErrOk;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         timer_q   <= timer_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   assign m_arvalid  = (state_q == StAr);
   assign m_araddr   = addr_q;
   assign m_arsize   = {1'b0, size_q};
   assign m_rready   = (state_q == StR);

   assign m_awvalid  = (state_q == StAww) && !aw_done_q;
   assign m_awaddr   = addr_q;
   assign m_awsize   = {1'b0, size_q};
   assign m_wvalid   = (state_q == StAww) && !w_done_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_bready   = (state_q == StB);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: scripted AXI-lite slave per transaction, expected
// responses queued when each request is issued and popped when the response appears.
module tb_lsu_axi_master;

   logic        clk;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        m_arvalid, m_arready;
   logic [31:0] m_araddr;
   logic [2:0]  m_arsize;
   logic        m_rvalid, m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_awvalid, m_awready;
   logic [31:0] m_awaddr;
   logic [2:0]  m_awsize;
   logic        m_wvalid, m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid, m_bready;
   logic [1:0]  m_bresp;

   lsu_axi_master #(
      .XLEN    (32),
      .TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_func3  (req_func3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .m_arvalid  (m_arvalid),
      .m_arready  (m_arready),
      .m_araddr   (m_araddr),
      .m_arsize   (m_arsize),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready),
      .m_rdata    (m_rdata),
      .m_rresp    (m_rresp),
      .m_awvalid  (m_awvalid),
      .m_awready  (m_awready),
      .m_awaddr   (m_awaddr),
      .m_awsize   (m_awsize),
      .m_wvalid   (m_wvalid),
      .m_wready   (m_wready),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .m_bresp    (m_bresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;

   // Observations of the most recent transaction.
   int          res_lat;
   int          res_nav;
   logic [31:0] res_rdata;
   logic [1:0]  res_err;
   logic [31:0] res_addr;
   logic [2:0]  res_size;
   logic [31:0] res_wdata;
   logic [3:0]  res_wstrb;
   logic        res_unstable;

   // Issues one request, plays the slave with the given per-channel ready delays, and waits
   // for resp_valid. Latency is counted in cycles from the accept cycle.
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [31:0] rdat,
                          input logic [1:0] xresp, input int ar_dly, input int aw_dly,
                          input int w_dly);
      int   ar_cnt, aw_cnt, w_cnt;
      logic ar_done, aw_done, w_done, r_done, b_done, w_seen;
      logic p_arv, p_awv, p_wv, p_rhs, p_bhs;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      ar_done = 0; aw_done = 0; w_done = 0; r_done = 0; b_done = 0; w_seen = 0;
      p_arv = 0; p_awv = 0; p_wv = 0; p_rhs = 0; p_bhs = 0;
      res_lat = -1; res_nav = 0; res_rdata = '0; res_err = '0; res_addr = '0;
      res_size = '0; res_wdata = '0; res_wstrb = '0; res_unstable = 0;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL req_ready_idle got=%b want=1", req_ready);
      end
      req_valid = 1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdat;
      for (int c = 1; c <= 40 && res_lat < 0; c++) begin
         @(negedge clk);
         req_valid = 0;
         if (p_arv && m_arready) ar_done = 1;
         if (p_awv && m_awready) aw_done = 1;
         if (p_wv && m_wready) w_done = 1;
         if (p_rhs) r_done = 1;
         if (p_bhs) b_done = 1;
         m_arready = 0; m_awready = 0; m_wready = 0;
         if (r_done) m_rvalid = 0;
         if (b_done) m_bvalid = 0;
         if (resp_valid) begin
            res_lat = c; res_rdata = resp_rdata; res_err = resp_err;
         end
         if (m_arvalid || m_awvalid) res_nav++;
         if (m_arvalid) begin
            if (res_nav > 1 && {m_araddr, m_arsize} !== {res_addr, res_size}) res_unstable = 1;
            res_addr = m_araddr; res_size = m_arsize;
            if (ar_cnt == ar_dly) begin
               m_arready = 1; m_rvalid = 1; m_rdata = rdat; m_rresp = xresp;
            end
            ar_cnt++;
         end
         if (m_awvalid) begin
            if (res_nav > 1 && {m_awaddr, m_awsize} !== {res_addr, res_size}) res_unstable = 1;
            res_addr = m_awaddr; res_size = m_awsize;
            if (aw_cnt == aw_dly) m_awready = 1;
            aw_cnt++;
         end
         if (m_wvalid) begin
            if (w_seen && {m_wdata, m_wstrb} !== {res_wdata, res_wstrb}) res_unstable = 1;
            res_wdata = m_wdata; res_wstrb = m_wstrb; w_seen = 1;
            if (w_cnt == w_dly) m_wready = 1;
            w_cnt++;
         end
         if (aw_done && w_done && !b_done && !m_bvalid) begin
            m_bvalid = 1; m_bresp = xresp;
         end
         p_arv = m_arvalid; p_awv = m_awvalid; p_wv = m_wvalid;
         p_rhs = m_rready && m_rvalid;
         p_bhs = m_bready && m_bvalid;
      end
      m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
      total++;
      if (res_lat < 0) begin
         bad++;
         $display("FAIL resp_wait got=no resp_valid want=resp_valid within 40 cycles");
      end
      total++;
      if (res_unstable !== 1'b0) begin
         bad++;
         $display("FAIL addr_data_stable got=changed want=stable while valid");
      end
      @(negedge clk);
      total++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL resp_single got={resp_valid,req_ready}=%b want=01", {resp_valid, req_ready});
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_rdata, resp_err, m_arvalid, m_rready, m_awvalid, m_wvalid,
           m_bready} !== {1'b1, 1'b0, 32'h0, 2'b00, 5'b00000}) begin
         bad++;
         $display("FAIL reset_state got rdy=%b rv=%b rd=%h err=%0d valids=%b want 1 0 0 0 00000",
                  req_ready, resp_valid, resp_rdata, resp_err,
                  {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
      end
      rst = 0;
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, m_arvalid, m_awvalid, m_wvalid} !== 5'b10000) begin
         bad++;
         $display("FAIL post_reset got=%b want=10000",
                  {req_ready, resp_valid, m_arvalid, m_awvalid, m_wvalid});
      end
   endtask

   task automatic test_load_word();
      exp_t e;
      e.rdata = 32'hDEAD_BEEF; e.err = 2'd0; e.lat = 3;
      sb.push_back(e);
      run_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err} !== {e.rdata, e.err}) begin
         bad++;
         $display("FAIL lw_data got=%h/%0d want=%h/%0d", res_rdata, res_err, e.rdata, e.err);
      end
      total++;
      if (res_lat !== e.lat) begin
         bad++;
         $display("FAIL lw_latency got=%0d want=%0d", res_lat, e.lat);
      end
      total++;
      if ({res_addr, res_size} !== {32'h8000_0004, 3'd2}) begin
         bad++;
         $display("FAIL lw_ar got=%h/%0d want=80000004/2", res_addr, res_size);
      end
   endtask

   task automatic test_load_ext();
      logic [31:0] t_addr [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002,
                                  32'h8000_0001, 32'h8000_0000};
      logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
      logic [31:0] t_rd   [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'hBEEF_0000, 32'hBEEF_0000,
                                  32'h0000_7F00, 32'h1234_8001};
      logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF,
                                  32'h0000_007F, 32'hFFFF_8001};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         e.rdata = t_exp[i]; e.err = 2'd0; e.lat = 3;
         sb.push_back(e);
         run_txn(1'b0, t_f3[i], t_addr[i], 32'h0, t_rd[i], 2'b00, 0, 0, 0);
         e = sb.pop_front();
         total++;
         if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
            bad++;
            $display("FAIL load_ext[%0d] got=%h/%0d/lat%0d want=%h/%0d/lat%0d", i, res_rdata,
                     res_err, res_lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_store();
      logic [31:0] t_addr [3] = '{32'h8000_0002, 32'h8000_0010, 32'h8000_0001};
      logic [2:0]  t_f3   [3] = '{3'b001, 3'b010, 3'b000};
      logic [31:0] t_wd   [3] = '{32'h0000_1234, 32'hCAFE_F00D, 32'h0000_00AB};
      int          t_awd  [3] = '{0, 0, 2};
      int          t_wdl  [3] = '{3, 0, 0};
      logic [31:0] t_ewd  [3] = '{32'h1234_0000, 32'hCAFE_F00D, 32'h0000_AB00};
      logic [3:0]  t_est  [3] = '{4'b1100, 4'b1111, 4'b0010};
      int          t_lat  [3] = '{6, 3, 5};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.rdata = 32'h0; e.err = 2'd0; e.lat = t_lat[i];
         sb.push_back(e);
         run_txn(1'b1, t_f3[i], t_addr[i], t_wd[i], 32'h0, 2'b00, 0, t_awd[i], t_wdl[i]);
         e = sb.pop_front();
         total++;
         if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
            bad++;
            $display("FAIL store_resp[%0d] got=%h/%0d/lat%0d want=%h/%0d/lat%0d", i, res_rdata,
                     res_err, res_lat, e.rdata, e.err, e.lat);
         end
         total++;
         if ({res_wdata, res_wstrb, res_addr, res_size} !==
             {t_ewd[i], t_est[i], t_addr[i], 1'b0, t_f3[i][1:0]}) begin
            bad++;
            $display("FAIL store_bus[%0d] got wd=%h st=%b a=%h sz=%0d want wd=%h st=%b a=%h",
                     i, res_wdata, res_wstrb, res_addr, res_size, t_ewd[i], t_est[i], t_addr[i]);
         end
      end
   endtask

   task automatic test_misaligned();
      logic        t_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  t_f3   [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
      logic [31:0] t_addr [4] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0008, 32'h8000_0003};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.rdata = 32'h0; e.err = 2'd1; e.lat = 1;
         sb.push_back(e);
         run_txn(t_we[i], t_f3[i], t_addr[i], 32'h1111_2222, 32'h3333_4444, 2'b00, 0, 0, 0);
         e = sb.pop_front();
         total++;
         if ({res_rdata, res_err, res_lat, res_nav} !== {e.rdata, e.err, e.lat, 32'd0}) begin
            bad++;
            $display("FAIL misaligned[%0d] got=%h/%0d/lat%0d/bus%0d want=%h/%0d/lat%0d/bus0", i,
                     res_rdata, res_err, res_lat, res_nav, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_bus_err();
      exp_t e;
      e.rdata = 32'h0; e.err = 2'd2; e.lat = 3;
      sb.push_back(e);
      run_txn(1'b1, 3'b010, 32'h8000_0020, 32'h5A5A_5A5A, 32'h0, 2'b10, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
         bad++;
         $display("FAIL sw_bresp got=%h/%0d/lat%0d want=%h/%0d/lat%0d", res_rdata, res_err,
                  res_lat, e.rdata, e.err, e.lat);
      end
      e.rdata = 32'h0; e.err = 2'd2; e.lat = 3;
      sb.push_back(e);
      run_txn(1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h0000_0055, 2'b11, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
         bad++;
         $display("FAIL lw_rresp got=%h/%0d/lat%0d want=%h/%0d/lat%0d", res_rdata, res_err,
                  res_lat, e.rdata, e.err, e.lat);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      e.rdata = 32'h0; e.err = 2'd3; e.lat = 9;
      sb.push_back(e);
      run_txn(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0BAD_0BAD, 2'b00, 1000, 0, 0);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
         bad++;
         $display("FAIL ar_timeout got=%h/%0d/lat%0d want=%h/%0d/lat%0d", res_rdata, res_err,
                  res_lat, e.rdata, e.err, e.lat);
      end
      total++;
      if (m_arvalid !== 1'b0) begin
         bad++;
         $display("FAIL arvalid_after_abort got=%b want=0", m_arvalid);
      end
      m_rvalid = 1; m_rdata = 32'h0BAD_0BAD; m_rresp = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({m_rready, resp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL late_rvalid[%0d] got={rready,resp_valid}=%b want=00", i,
                     {m_rready, resp_valid});
         end
      end
      m_rvalid = 0;
      e.rdata = 32'h0; e.err = 2'd3; e.lat = 9;
      sb.push_back(e);
      run_txn(1'b1, 3'b010, 32'h8000_0044, 32'h7777_7777, 32'h0, 2'b00, 0, 0, 1000);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
         bad++;
         $display("FAIL w_timeout got=%h/%0d/lat%0d want=%h/%0d/lat%0d", res_rdata, res_err,
                  res_lat, e.rdata, e.err, e.lat);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      req_valid = 1; req_we = 0; req_func3 = 3'b010; req_addr = 32'h8000_0050;
      @(negedge clk);
      req_valid = 0; m_arready = 1;
      @(negedge clk);
      m_arready = 0;
      total++;
      if (m_rready !== 1'b1) begin
         bad++;
         $display("FAIL reach_r got rready=%b want=1", m_rready);
      end
      #2 rst = 1;
      #1;
      total++;
      if ({req_ready, resp_valid, resp_rdata, resp_err, m_arvalid, m_rready, m_awvalid, m_wvalid,
           m_bready} !== {1'b1, 1'b0, 32'h0, 2'b00, 5'b00000}) begin
         bad++;
         $display("FAIL reset_mid got rdy=%b rv=%b rd=%h err=%0d valids=%b want 1 0 0 0 00000",
                  req_ready, resp_valid, resp_rdata, resp_err,
                  {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
      end
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_resp_after_reset[%0d] got=%b want=0", i, resp_valid);
         end
      end
      e.rdata = 32'h0102_0304; e.err = 2'd0; e.lat = 3;
      sb.push_back(e);
      run_txn(1'b0, 3'b010, 32'h8000_0054, 32'h0, 32'h0102_0304, 2'b00, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
         bad++;
         $display("FAIL after_reset_lw got=%h/%0d/lat%0d want=%h/%0d/lat%0d", res_rdata, res_err,
                  res_lat, e.rdata, e.err, e.lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] data [8];
      int          off  [8];
      logic [31:0] tmp;
      exp_t        e;
      for (int i = 0; i < 8; i++) begin
         data[i] = $urandom;
         off[i]  = $urandom_range(0, 3);
         tmp     = data[i] >> (8 * off[i]);
         e.rdata = (i % 2 == 0) ? {24'h0, tmp[7:0]} : 32'h0;
         e.err   = 2'd0;
         e.lat   = 3;
         sb.push_back(e);
      end
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            run_txn(1'b0, 3'b100, 32'h8000_1000 + 32'(4 * i + off[i]), 32'h0, data[i], 2'b00,
                    0, 0, 0);
         end else begin
            run_txn(1'b1, 3'b010, 32'h8000_1000 + 32'(4 * i), data[i], 32'h0, 2'b00, 0, 0, 0);
            total++;
            if ({res_wdata, res_wstrb} !== {data[i], 4'b1111}) begin
               bad++;
               $display("FAIL b2b_wdata[%0d] got=%h/%b want=%h/1111", i, res_wdata, res_wstrb,
                        data[i]);
            end
         end
         e = sb.pop_front();
         total++;
         if ({res_rdata, res_err, res_lat} !== {e.rdata, e.err, e.lat}) begin
            bad++;
            $display("FAIL b2b_resp[%0d] got=%h/%0d/lat%0d want=%h/%0d/lat%0d", i, res_rdata,
                     res_err, res_lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1;
      req_valid = 0; req_we = 0; req_func3 = '0; req_addr = '0; req_wdata = '0;
      m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
      test_reset();
      test_load_word();
      test_load_ext();
      test_store();
      test_misaligned();
      test_bus_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
